// File: rtl/irq_controller_pkg.sv
// Shared types and default widths for the interrupt controller slice.
package irq_controller_pkg;

    localparam int M_DEF = 8;
    localparam int N_DEF = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

endpackage

// File: rtl/priority_encoder.sv
// Combinational priority encoder: the highest set bit wins.
module priority_encoder
    import irq_controller_pkg::*;
#(
    parameter int m = M_DEF,
    parameter int n = N_DEF
) (
    input  logic [m-1:0] bits,
    output logic [n-1:0] idx,
    output logic         any_set
);

    // Later iterations overwrite earlier ones, so the top set bit ends up in idx.
    always_comb begin
        idx = '0;
        for (int i = 0; i < m; i++) begin
            if (bits[i]) begin
                idx = n'(i);
            end
        end
    end

    assign any_set = |bits;

endmodule

// File: rtl/irq_controller.sv
// Edge-captured, maskable interrupt front-end presenting one request at a time
// to the CPU through a valid/ack/eoi handshake.
module irq_controller
    import irq_controller_pkg::*;
#(
    parameter int m = M_DEF,
    parameter int n = N_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [m-1:0] req,
    input  logic         mask_we,
    input  logic [m-1:0] mask_in,
    output logic         irq_valid,
    output logic [n-1:0] irq_id,
    input  logic         irq_ack,
    input  logic         eoi,
    output logic         in_service,
    output logic [m-1:0] pending
);

    state_t       state_reg, state_next;
    logic [m-1:0] req_d_reg;
    logic [m-1:0] pending_reg, pending_next;
    logic [m-1:0] mask_reg;
    logic [n-1:0] irq_id_reg, irq_id_next;
    logic         irq_valid_reg, irq_valid_next;
    logic         in_service_reg, in_service_next;

    logic [m-1:0] rise;
    logic [m-1:0] active;
    logic [m-1:0] clr;
    logic [n-1:0] win_idx;
    logic         any_active;

    assign rise   = req & ~req_d_reg;
    assign active = pending_reg & ~mask_reg;

    priority_encoder #(
        .m(m),
        .n(n)
    ) u_prio (
        .bits    (active),
        .idx     (win_idx),
        .any_set (any_active)
    );

    always_comb begin
        state_next      = state_reg;
        irq_valid_next  = irq_valid_reg;
        irq_id_next     = irq_id_reg;
        in_service_next = in_service_reg;
        clr             = '0;
        case (state_reg)
            IDLE: begin
                if (any_active) begin
                    irq_id_next    = win_idx;
                    irq_valid_next = 1'b1;
                    state_next     = REQ;
                end
            end
            REQ: begin
                // irq_id stays frozen here; only the ack moves us on.
                if (irq_ack) begin
                    clr[irq_id_reg] = 1'b1;
                    irq_valid_next  = 1'b0;
                    in_service_next = 1'b1;
                    state_next      = SERVICE;
                end
            end
            SERVICE: begin
                if (eoi) begin
                    in_service_next = 1'b0;
                    state_next      = IDLE;
                end
            end
            default: begin
                irq_valid_next  = 1'b0;
                in_service_next = 1'b0;
                state_next      = IDLE;
            end
        endcase
        // A fresh edge in the same cycle as the ack keeps the line pending.
        pending_next = (pending_reg & ~clr) | rise;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            req_d_reg      <= '0;
            pending_reg    <= '0;
            mask_reg       <= '0;
            irq_id_reg     <= '0;
            irq_valid_reg  <= 1'b0;
            in_service_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            req_d_reg      <= req;
            pending_reg    <= pending_next;
            irq_id_reg     <= irq_id_next;
            irq_valid_reg  <= irq_valid_next;
            in_service_reg <= in_service_next;
            if (mask_we) begin
                mask_reg <= mask_in;
            end
        end
    end

    assign irq_valid  = irq_valid_reg;
    assign irq_id     = irq_id_reg;
    assign in_service = in_service_reg;
    assign pending    = pending_reg;

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed scenarios plus a randomized
// run compared cycle by cycle against a behavioural model.
module tb_irq_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       mask_we;
    logic [7:0] mask_in;
    logic       irq_valid;
    logic [2:0] irq_id;
    logic       irq_ack;
    logic       eoi;
    logic       in_service;
    logic [7:0] pending;

    int total = 0;
    int bad   = 0;

    irq_controller #(.m(8), .n(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .mask_we    (mask_we),
        .mask_in    (mask_in),
        .irq_valid  (irq_valid),
        .irq_id     (irq_id),
        .irq_ack    (irq_ack),
        .eoi        (eoi),
        .in_service (in_service),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    // Behavioural model: one presented request at a time, chosen as floor(log2(active)).
    logic [7:0] m_pend, m_mask, m_prev_req;
    bit         m_presented, m_serving;
    int         m_id;

    function automatic void model_reset();
        m_pend = '0; m_mask = '0; m_prev_req = '0;
        m_presented = 0; m_serving = 0; m_id = 0;
    endfunction

    function automatic void model_step(logic [7:0] r, logic mw, logic [7:0] mi, logic a, logic e);
        logic [7:0] active_now, new_pend;
        active_now = m_pend & ~m_mask;
        new_pend   = m_pend;
        if (m_presented && a) new_pend[m_id] = 1'b0;
        new_pend = new_pend | (r & ~m_prev_req);
        if (m_presented) begin
            if (a) begin
                m_presented = 0;
                m_serving   = 1;
            end
        end else if (m_serving) begin
            if (e) m_serving = 0;
        end else if (active_now != 0) begin
            m_presented = 1;
            m_id = $clog2(int'(active_now) + 1) - 1;
        end
        m_pend     = new_pend;
        m_prev_req = r;
        if (mw) m_mask = mi;
    endfunction

    // One clock: drive at negedge, let the edge happen, advance the model, return at next negedge.
    task automatic cyc(input logic [7:0] r, input logic mw, input logic [7:0] mi,
                       input logic a, input logic e);
        req = r; mask_we = mw; mask_in = mi; irq_ack = a; eoi = e;
        @(posedge clk);
        model_step(r, mw, mi, a, e);
        @(negedge clk);
    endtask

    task automatic test_reset();
        cyc(8'h01, 0, 8'h00, 0, 0);
        cyc(8'h01, 0, 8'h00, 0, 0);
        total++;
        if (irq_valid !== 1'b1) begin
            bad++; $display("FAIL reset_pre_valid: got %b want 1", irq_valid);
        end
        #2 rst_n = 1'b0;
        req = '0;
        #1;
        total++;
        if ({irq_valid, irq_id, in_service, pending} !== 13'd0) begin
            bad++;
            $display("FAIL reset_async: valid=%b id=%0d srv=%b pend=%h want all 0",
                     irq_valid, irq_id, in_service, pending);
        end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(8'h00, 0, 8'h00, 0, 0);
            total++;
            if (irq_valid !== 1'b0) begin
                bad++; $display("FAIL reset_idle: cycle %0d valid=%b want 0", i, irq_valid);
            end
        end
        $display("reset: done");
    endtask

    task automatic test_single();
        cyc(8'h04, 0, 8'h00, 0, 0);
        total++;
        if (pending !== 8'h04 || irq_valid !== 1'b0) begin
            bad++; $display("FAIL single_pend: pend=%h valid=%b want 04 0", pending, irq_valid);
        end
        cyc(8'h04, 0, 8'h00, 0, 0);
        total++;
        if (irq_valid !== 1'b1 || irq_id !== 3'd2) begin
            bad++; $display("FAIL single_present: valid=%b id=%0d want 1 2", irq_valid, irq_id);
        end
        cyc(8'h04, 0, 8'h00, 1, 0);
        total++;
        if (pending !== 8'h00 || in_service !== 1'b1 || irq_valid !== 1'b0) begin
            bad++; $display("FAIL single_ack: pend=%h srv=%b valid=%b want 00 1 0",
                            pending, in_service, irq_valid);
        end
        cyc(8'h04, 0, 8'h00, 0, 1);
        total++;
        if (in_service !== 1'b0) begin
            bad++; $display("FAIL single_eoi: srv=%b want 0", in_service);
        end
        cyc(8'h00, 0, 8'h00, 0, 0);
        $display("single: id 2 served");
    endtask

    task automatic test_priority_freeze();
        cyc(8'h02, 0, 8'h00, 0, 0);
        cyc(8'h02, 0, 8'h00, 0, 0);
        cyc(8'h42, 0, 8'h00, 0, 0);
        cyc(8'h42, 0, 8'h00, 0, 0);
        total++;
        if (irq_valid !== 1'b1 || irq_id !== 3'd1 || pending !== 8'h42) begin
            bad++; $display("FAIL freeze: valid=%b id=%0d pend=%h want 1 1 42",
                            irq_valid, irq_id, pending);
        end
        cyc(8'h42, 0, 8'h00, 1, 0);
        cyc(8'h42, 0, 8'h00, 0, 1);
        total++;
        if (irq_valid !== 1'b0 || in_service !== 1'b0) begin
            bad++; $display("FAIL freeze_eoi: valid=%b srv=%b want 0 0", irq_valid, in_service);
        end
        cyc(8'h42, 0, 8'h00, 0, 0);
        total++;
        if (irq_valid !== 1'b1 || irq_id !== 3'd6) begin
            bad++; $display("FAIL freeze_next: valid=%b id=%0d want 1 6", irq_valid, irq_id);
        end
        cyc(8'h42, 0, 8'h00, 1, 0);
        cyc(8'h00, 0, 8'h00, 0, 1);
        $display("priority_freeze: id 1 then id 6 served");
    endtask

    task automatic test_mask();
        cyc(8'h00, 1, 8'h80, 0, 0);
        cyc(8'h80, 0, 8'h00, 0, 0);
        cyc(8'h80, 0, 8'h00, 0, 0);
        cyc(8'h80, 0, 8'h00, 0, 0);
        total++;
        if (pending !== 8'h80 || irq_valid !== 1'b0) begin
            bad++; $display("FAIL mask_hide: pend=%h valid=%b want 80 0", pending, irq_valid);
        end
        cyc(8'h80, 1, 8'h00, 0, 0);
        cyc(8'h80, 0, 8'h00, 0, 0);
        total++;
        if (irq_valid !== 1'b1 || irq_id !== 3'd7) begin
            bad++; $display("FAIL mask_clear: valid=%b id=%0d want 1 7", irq_valid, irq_id);
        end
        cyc(8'h80, 0, 8'h00, 1, 0);
        cyc(8'h00, 0, 8'h00, 0, 1);
        $display("mask: id 7 held then served");
    endtask

    task automatic test_collision();
        cyc(8'h08, 0, 8'h00, 0, 0);
        cyc(8'h08, 0, 8'h00, 0, 0);
        cyc(8'h00, 0, 8'h00, 0, 0);
        total++;
        if (irq_valid !== 1'b1 || irq_id !== 3'd3) begin
            bad++; $display("FAIL coll_present: valid=%b id=%0d want 1 3", irq_valid, irq_id);
        end
        cyc(8'h08, 0, 8'h00, 1, 0);
        total++;
        if (pending !== 8'h08 || in_service !== 1'b1) begin
            bad++; $display("FAIL coll_setwins: pend=%h srv=%b want 08 1", pending, in_service);
        end
        cyc(8'h08, 0, 8'h00, 0, 1);
        cyc(8'h08, 0, 8'h00, 0, 0);
        total++;
        if (irq_valid !== 1'b1 || irq_id !== 3'd3) begin
            bad++; $display("FAIL coll_again: valid=%b id=%0d want 1 3", irq_valid, irq_id);
        end
        cyc(8'h08, 0, 8'h00, 1, 0);
        cyc(8'h00, 0, 8'h00, 0, 1);
        $display("collision: id 3 served twice");
    endtask

    task automatic test_ignored();
        cyc(8'h00, 0, 8'h00, 1, 0);
        total++;
        if (irq_valid !== 1'b0 || in_service !== 1'b0 || pending !== 8'h00) begin
            bad++; $display("FAIL ign_ack_idle: valid=%b srv=%b pend=%h want 0 0 00",
                            irq_valid, in_service, pending);
        end
        cyc(8'h20, 0, 8'h00, 0, 0);
        cyc(8'h20, 0, 8'h00, 0, 0);
        cyc(8'h20, 0, 8'h00, 0, 1);
        total++;
        if (irq_valid !== 1'b1 || in_service !== 1'b0 || irq_id !== 3'd5 || pending !== 8'h20) begin
            bad++; $display("FAIL ign_eoi_req: valid=%b srv=%b id=%0d pend=%h want 1 0 5 20",
                            irq_valid, in_service, irq_id, pending);
        end
        cyc(8'h20, 0, 8'h00, 1, 1);
        total++;
        if (irq_valid !== 1'b0 || in_service !== 1'b1) begin
            bad++; $display("FAIL ign_both: valid=%b srv=%b want 0 1", irq_valid, in_service);
        end
        cyc(8'h20, 0, 8'h00, 0, 0);
        total++;
        if (in_service !== 1'b1) begin
            bad++; $display("FAIL ign_stay_srv: srv=%b want 1", in_service);
        end
        cyc(8'h00, 0, 8'h00, 0, 1);
        $display("ignored: strobes checked");
    endtask

    task automatic test_random();
        logic [7:0] r, mi;
        logic       mw, a, e;
        r = '0;
        for (int i = 0; i < 600; i++) begin
            r  = r ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            mw = ($urandom_range(0, 15) == 0);
            mi = 8'($urandom) & 8'($urandom);
            a  = ($urandom_range(0, 3) == 0);
            e  = ($urandom_range(0, 3) == 0);
            if (m_presented && a) $display("random: ack id=%0d at step %0d", m_id, i);
            cyc(r, mw, mi, a, e);
            total++;
            if (irq_valid !== m_presented || in_service !== m_serving ||
                pending !== m_pend || irq_id !== 3'(m_id)) begin
                bad++;
                $display("FAIL random step %0d: valid=%b srv=%b pend=%h id=%0d want %b %b %h %0d",
                         i, irq_valid, in_service, pending, irq_id,
                         m_presented, m_serving, m_pend, m_id);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; req = '0; mask_we = 0; mask_in = '0; irq_ack = 0; eoi = 0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_single();
        test_priority_freeze();
        test_mask();
        test_collision();
        test_ignored();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Interrupt front-end that feeds the priority encoder stage: captures rising edges on m request lines into a pending register and applies a mask.
- Presents the highest-priority active request to a CPU through a valid/ack/end-of-interrupt handshake.
- Instantiates the codebase's priority_encoder to compute the winning index.
- Sits between raw peripheral request lines and the CPU interrupt interface.

Parameters:
- m, 8, number of request lines (pending/mask width).
- n, 3, index width; m = 2**n required.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  m  raw request lines, synchronous to clk; level per line, rising edge = new request.
- mask_we  input  1  load mask register from mask_in this cycle.
- mask_in  input  m  new mask value; 1 = line masked.
- irq_valid  output  1  request presented to CPU.
- irq_id  output  n  index of presented request; stable while irq_valid.
- irq_ack  input  1  CPU accepts presented request.
- eoi  input  1  CPU end-of-interrupt; ends service.
- in_service  output  1  CPU is servicing an accepted request.
- pending  output  m  current pending register, for debug/readback.

Behaviour:
- Reset (async, rst_n low): req_d, pending, mask all 0; irq_valid=0, irq_id=0, in_service=0; FSM=IDLE. Reset mid-handshake abandons the request; there is no recovery.
- Edge detect: req_d <= req each cycle. rise = req & ~req_d. Rising edges set pending bits: pending[i] <= 1 on rise[i].
- Mask: on mask_we, mask <= mask_in on the next edge. Masking never clears pending; it only hides the line.
- active = pending & ~mask. Combinational priority_encoder(active) -> win_idx. Highest index has highest priority, so bit m-1 wins and bit 0 is lowest.
- FSM, states IDLE, REQ, SERVICE:
  - IDLE: if |active, then irq_id <= win_idx, irq_valid <= 1, go REQ. Otherwise stay.
  - REQ: irq_id is frozen. A later higher-priority arrival does not preempt it, and a mask change does not withdraw it. On irq_ack: pending[irq_id] cleared, irq_valid <= 0, in_service <= 1, go SERVICE.
  - SERVICE: on eoi: in_service <= 0, go IDLE. New edges keep accumulating in pending.
- Latency:
  - Edge sampled at cycle t -> pending bit set at t+1 -> irq_valid high at t+2 (from IDLE, unmasked).
  - After eoi, the next pending request is presented 2 cycles after the eoi edge: IDLE entry, then present.
- Simultaneous events:
  - New rising edge on line irq_id in the same cycle as irq_ack: set wins, so the bit stays pending and the line is re-presented later.
  - irq_ack in IDLE or SERVICE is ignored.
  - eoi in IDLE or REQ is ignored.
  - irq_ack and eoi together in REQ: ack is taken, eoi is ignored, and the FSM stays in SERVICE.
- All-masked or empty active: stay in IDLE, irq_valid=0.
- No nesting: only one request is in flight at a time.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, REQ=2'd1, SERVICE=2'd2) and default widths M_DEF=8, N_DEF=3.
- Sub-module: priority_encoder #(.m(m), .n(n)), instantiated once on active. The edge-detect, pending, mask and FSM logic stays in irq_controller.

Test Plan:
- Reset then idle: rst_n low mid-run -> all outputs 0 immediately. With req=0 for 10 cycles after release -> irq_valid stays 0.
- Single request: req[2] 0->1 at cycle t -> pending=8'b0000_0100 at t+1, irq_valid=1 and irq_id=2 at t+2. irq_ack -> pending=0, in_service=1. eoi -> in_service=0.
- Priority and freeze: req[1] rises; while in REQ with irq_id=1, req[6] rises -> irq_id stays 1. After ack and eoi -> irq_id=6 presented 2 cycles after eoi.
- Masking: mask_in=8'b1000_0000 with mask_we, then req[7] rises -> pending[7]=1, irq_valid=0. Clearing the mask -> irq_valid=1, irq_id=7.
- Set/clear collision: in REQ with irq_id=3, irq_ack in the same cycle as a fresh rising edge on req[3] -> pending[3] remains 1. After eoi -> id 3 presented again.
- Ignored strobes: irq_ack in IDLE and eoi in REQ -> no state or output change. Both together in REQ -> SERVICE entered, in_service=1.
